// File: rtl/beat_pkg.sv
// Shared constants, player state encoding and small helpers for the beat player.
package beat_pkg;

  localparam int         NUM_INS     = 4;
  localparam int         NUM_BEATS   = 8;
  localparam logic [7:0] DEFAULT_BPM = 8'd120;
  localparam logic [3:0] TIMING_IDLE = 4'd0;

  // Player FSM: playback either stopped or running.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } play_state_e;

  // A timing code names a beat only when it lies in 1..NUM_BEATS.
  function automatic logic is_beat(input logic [3:0] t);
    return (t != TIMING_IDLE) && (t <= 4'(NUM_BEATS));
  endfunction

  // Beat 1..8 maps to pattern bit 0..7; codes outside that range never fire.
  function automatic logic [2:0] beat_bit(input logic [3:0] t);
    return t[2:0] - 3'd1;
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Per-instrument note-on timer: a trigger loads GATE_CYCLES, the count runs down
// by one per cycle, and the gate level is high while the count is nonzero.
// Reloading while active restarts the count without a low cycle on gate.
module gate_timer #(
  parameter int GATE_CYCLES = 2_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  output logic gate
);

  localparam int            CW       = $clog2(GATE_CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(GATE_CYCLES);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, then reload, then count down towards zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register, cleared asynchronously so the gate drops the instant reset asserts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gate = (cnt_q != '0);

endmodule

// File: rtl/beat_player.sv
// Beat player: stores four 8-beat instrument patterns and a BPM value, produces
// an eighth-note beat_tick from a drift-free phase accumulator, and fires a
// one-cycle trigger plus a fixed-length gate per instrument on each beat event.
module beat_player
  import beat_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int GATE_CYCLES = 2_500_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          data_in,
  input  logic                ld_ins1,
  input  logic                ld_ins2,
  input  logic                ld_ins3,
  input  logic                ld_ins4,
  input  logic                ld_bpm,
  input  logic                play,
  input  logic [3:0]          timing,
  output logic                beat_tick,
  output logic [NUM_INS-1:0]  trig,
  output logic [NUM_INS-1:0]  gate,
  output logic                bpm_err
);

  // Eighth notes at bpm quarter-notes per minute: period = CLK_HZ*60/(2*bpm)
  // cycles, so accumulating bpm each cycle against CLK_HZ*30 gives the rate
  // exactly, with the remainder carried so there is no long-term drift.
  localparam logic [31:0] THR = 32'(CLK_HZ * 30);

  play_state_e                  state_q, state_d;
  logic [NUM_INS-1:0][7:0]      pat_q, pat_d;
  logic [7:0]                   bpm_q, bpm_d;
  logic                         bpm_err_q, bpm_err_d;
  logic [31:0]                  acc_q, acc_d;
  logic [3:0]                   timing_q, timing_d;
  logic [NUM_INS-1:0]           trig_q, trig_d;
  logic                         beat_tick_q, beat_tick_d;

  logic                         run_active;
  logic                         beat_event;
  logic [2:0]                   beat_idx;
  logic [NUM_INS-1:0]           ld_ins;
  logic [NUM_INS-1:0]           fire;
  logic [31:0]                  acc_sum;

  assign ld_ins = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};

  // Playback is live only while in RUN and play is still held; the cycle play
  // drops already behaves as IDLE, so gates are cut one cycle after the fall.
  assign run_active = (state_q == ST_RUN) && play;
  assign beat_event = run_active && (timing != timing_q) && is_beat(timing);
  assign beat_idx   = beat_bit(timing);
  assign acc_sum    = acc_q + {24'd0, bpm_q};

  // Next-state logic for the player FSM, accumulator, triggers and registers.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can leave it unassigned and infer a latch.
    state_d     = play ? ST_RUN : ST_IDLE;
    pat_d       = pat_q;
    bpm_d       = bpm_q;
    bpm_err_d   = bpm_err_q;
    acc_d       = '0;
    beat_tick_d = 1'b0;
    timing_d    = timing;
    fire        = '0;

    // Beat events read the pattern as it stood before this cycle's loads.
    for (int k = 0; k < NUM_INS; k++) begin
      fire[k] = beat_event && pat_q[k][beat_idx];
    end
    trig_d = fire;

    if (run_active) begin
      if (acc_sum >= THR) begin
        acc_d       = acc_sum - THR;
        beat_tick_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end

    // Simultaneous strobes all take the same switch value.
    for (int k = 0; k < NUM_INS; k++) begin
      if (ld_ins[k]) begin
        pat_d[k] = data_in;
      end
    end

    // A zero BPM would stop the tick forever, so it is replaced and flagged.
    if (ld_bpm) begin
      if (data_in != 8'd0) begin
        bpm_d     = data_in;
        bpm_err_d = 1'b0;
      end else begin
        bpm_d     = DEFAULT_BPM;
        bpm_err_d = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      // NOTE: the pattern registers are reset like any other state because their cleared value is visible behaviour (no triggers after reset).
      pat_q       <= '0;
      bpm_q       <= DEFAULT_BPM;
      bpm_err_q   <= 1'b0;
      acc_q       <= '0;
      timing_q    <= TIMING_IDLE;
      trig_q      <= '0;
      beat_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      pat_q       <= pat_d;
      bpm_q       <= bpm_d;
      bpm_err_q   <= bpm_err_d;
      acc_q       <= acc_d;
      timing_q    <= timing_d;
      trig_q      <= trig_d;
      beat_tick_q <= beat_tick_d;
    end
  end

  // One gate timer per instrument; leaving RUN clears them all.
  for (genvar k = 0; k < NUM_INS; k++) begin : g_gate
    gate_timer #(
      .GATE_CYCLES(GATE_CYCLES)
    ) u_gate (
      .clk   (clk),
      .reset (reset),
      .clear (!run_active),
      .load  (fire[k]),
      .gate  (gate[k])
    );
  end

  assign beat_tick = beat_tick_q;
  assign trig      = trig_q;
  assign bpm_err   = bpm_err_q;

endmodule

// File: tb/tb_beat_player.sv
// Self-checking bench for beat_player: a behavioural model pushes the expected
// outputs of every clock edge into a queue and a monitor pops and compares them
// half a cycle later; directed scenarios add timing measurements on top.
module tb_beat_player;

  localparam int CLK_HZ = 100;
  localparam int GATE   = 10;
  localparam int THR    = CLK_HZ * 30;

  typedef struct packed {
    logic [3:0] trig;
    logic [3:0] gate;
    logic       tick;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       ld_ins1 = 1'b0, ld_ins2 = 1'b0, ld_ins3 = 1'b0, ld_ins4 = 1'b0;
  logic       ld_bpm = 1'b0;
  logic       play = 1'b0;
  logic [3:0] timing = 4'd0;
  logic       beat_tick;
  logic [3:0] trig;
  logic [3:0] gate;
  logic       bpm_err;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t exp_q[$];

  // Reference model state, kept in spec terms.
  logic [7:0] m_pat[4];
  int         m_bpm;
  bit         m_err;
  int         m_acc;
  bit         m_running;
  int         m_tprev;
  int         m_rem[4];

  beat_player #(
    .CLK_HZ(CLK_HZ),
    .GATE_CYCLES(GATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .ld_ins1   (ld_ins1),
    .ld_ins2   (ld_ins2),
    .ld_ins3   (ld_ins3),
    .ld_ins4   (ld_ins4),
    .ld_bpm    (ld_bpm),
    .play      (play),
    .timing    (timing),
    .beat_tick (beat_tick),
    .trig      (trig),
    .gate      (gate),
    .bpm_err   (bpm_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_pat[k] = 8'd0;
      m_rem[k] = 0;
    end
    m_bpm     = 120;
    m_err     = 1'b0;
    m_acc     = 0;
    m_running = 1'b0;
    m_tprev   = 0;
  endtask

  // One clock edge of the reference model, using the inputs held at that edge.
  task automatic model_step();
    exp_t       e;
    bit         run_now;
    bit         ev;
    int         t;
    logic [3:0] ld;
    ld      = {ld_ins4, ld_ins3, ld_ins2, ld_ins1};
    run_now = m_running && play;
    t       = int'(timing);
    ev      = run_now && (t != m_tprev) && (t >= 1) && (t <= 8);
    e       = '0;
    for (int k = 0; k < 4; k++) begin
      if (!run_now) begin
        m_rem[k] = 0;
      end else if (ev && m_pat[k][t-1]) begin
        m_rem[k]  = GATE;
        e.trig[k] = 1'b1;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
      end
      e.gate[k] = (m_rem[k] > 0);
    end
    if (run_now) begin
      m_acc += m_bpm;
      if (m_acc >= THR) begin
        m_acc -= THR;
        e.tick = 1'b1;
      end
    end else begin
      m_acc = 0;
    end
    for (int k = 0; k < 4; k++) begin
      if (ld[k]) m_pat[k] = data_in;
    end
    if (ld_bpm) begin
      if (data_in != 8'd0) begin
        m_bpm = int'(data_in);
        m_err = 1'b0;
      end else begin
        m_bpm = 120;
        m_err = 1'b1;
      end
    end
    m_running = play;
    m_tprev   = t;
    e.err     = m_err;
    exp_q.push_back(e);
  endtask

  // Advance one clock; returns at the following negedge with inputs unchanged.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Cycles until the next beat_tick (bounded); an expired bound is a failure.
  task automatic wait_tick(input string name, output int n);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      cyc();
      n++;
      if (beat_tick === 1'b1) return;
    end
    check({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  // Monitor: every pushed expectation is compared at the negedge after its edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("trig", 32'(trig), 32'(e.trig));
      check("gate", 32'(gate), 32'(e.gate));
      check("beat_tick", 32'(beat_tick), 32'(e.tick));
      check("bpm_err", 32'(bpm_err), 32'(e.err));
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    model_reset();

    // Reset state.
    #12;
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_tick", 32'(beat_tick), 32'd0);
    check("rst_err", 32'(bpm_err), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // BPM 60: first tick 50 cycles after entering RUN, then every 50.
    ld_bpm = 1'b1; data_in = 8'd60;
    cyc();
    ld_bpm = 1'b0; play = 1'b1;
    wait_tick("first_tick", n);
    check("first_tick_latency", 32'(n - 1), 32'd50);
    wait_tick("tick60", n);
    check("tick_period_60", 32'(n), 32'd50);
    check("bpm_err_60", 32'(bpm_err), 32'd0);

    // Zero BPM load: default 120 (25-cycle ticks) with error flag.
    ld_bpm = 1'b1; data_in = 8'd0;
    cyc();
    ld_bpm = 1'b0;
    check("bpm_err_zero", 32'(bpm_err), 32'd1);
    wait_tick("sync120", n);
    wait_tick("tick120a", n);
    check("tick_period_120a", 32'(n), 32'd25);
    wait_tick("tick120b", n);
    check("tick_period_120b", 32'(n), 32'd25);
    ld_bpm = 1'b1; data_in = 8'd200;
    cyc();
    ld_bpm = 1'b0;
    check("bpm_err_cleared", 32'(bpm_err), 32'd0);

    // Patterns and beat-driven triggers.
    play = 1'b0; timing = 4'd0;
    cyc(); cyc();
    ld_ins1 = 1'b1; data_in = 8'b0000_0101;
    cyc();
    ld_ins1 = 1'b0; ld_ins2 = 1'b1; data_in = 8'hFF;
    cyc();
    ld_ins2 = 1'b0;
    play = 1'b1;
    cyc();
    timing = 4'd1;
    cyc();
    check("beat1_trig", 32'(trig), 32'b0011);
    check("beat1_gate", 32'(gate), 32'b0011);
    cyc();
    check("beat1_trig_one_cycle", 32'(trig), 32'd0);
    repeat (8) cyc();
    check("gate_last_cycle", 32'(gate), 32'b0011);
    cyc();
    check("gate_expired", 32'(gate), 32'd0);

    // Beat 2 with a coinciding pattern load: the old pattern decides.
    timing = 4'd2; ld_ins1 = 1'b1; data_in = 8'hFF;
    cyc();
    ld_ins1 = 1'b0;
    check("beat2_old_pattern", 32'(trig), 32'b0010);
    repeat (3) cyc();
    timing = 4'd3;
    cyc();
    check("beat3_trig", 32'(trig), 32'b0011);
    repeat (12) cyc();

    // Retrigger 4 cycles after the first: gate stays high 14 cycles.
    timing = 4'd4;
    cyc();
    check("beat4_new_pattern", 32'(trig), 32'b0011);
    cnt = (gate[1] === 1'b1) ? 1 : 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) timing = 4'd5;
      cyc();
      if (gate[1] === 1'b1) cnt++;
      else break;
    end
    check("gate_continuous", 32'(cnt), 32'd14);
    repeat (12) cyc();

    // Idle code and out-of-range codes never trigger.
    timing = 4'd0; cyc();
    check("timing0_no_trig", 32'(trig), 32'd0);
    timing = 4'd9; cyc();
    check("timing9_no_trig", 32'(trig), 32'd0);
    timing = 4'd15; cyc();
    repeat (12) cyc();

    // Play falls 3 cycles into a gate: gate cut at once, no tick.
    timing = 4'd6;
    cyc();
    repeat (3) cyc();
    check("gate_before_stop", 32'(gate), 32'b0011);
    play = 1'b0;
    cyc();
    check("stop_gate", 32'(gate), 32'd0);
    check("stop_tick", 32'(beat_tick), 32'd0);
    // Restart at BPM 200 from a cleared accumulator: first tick after 15 cycles.
    play = 1'b1;
    wait_tick("restart", n);
    check("tick_after_restart", 32'(n - 1), 32'd15);

    // Asynchronous reset mid-gate, between clock edges.
    timing = 4'd7;
    cyc();
    cyc();
    check("gate_before_reset", 32'(gate), 32'b0011);
    #2 reset = 1'b0;
    #1;
    check("async_rst_trig", 32'(trig), 32'd0);
    check("async_rst_gate", 32'(gate), 32'd0);
    check("async_rst_tick", 32'(beat_tick), 32'd0);
    check("async_rst_err", 32'(bpm_err), 32'd0);
    model_reset();
    #1 reset = 1'b1;
    cyc();
    for (int t = 1; t <= 8; t++) begin
      timing = 4'(t);
      cyc();
      check("post_reset_no_trig", 32'(trig), 32'd0);
    end

    // Randomised traffic checked only through the scoreboard.
    data_in = 8'($urandom);
    ld_ins1 = 1'b1; ld_ins2 = 1'b1; ld_ins3 = 1'b1; ld_ins4 = 1'b1;
    cyc();
    ld_ins1 = 1'b0; ld_ins2 = 1'b0; ld_ins3 = 1'b0; ld_ins4 = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      data_in = 8'($urandom);
      ld_ins1 = ($urandom_range(0, 39) == 0);
      ld_ins2 = ($urandom_range(0, 39) == 0);
      ld_ins3 = ($urandom_range(0, 39) == 0);
      ld_ins4 = ($urandom_range(0, 39) == 0);
      ld_bpm  = ($urandom_range(0, 79) == 0);
      if (ld_bpm && $urandom_range(0, 3) == 0) data_in = 8'd0;
      if ($urandom_range(0, 59) == 0) play = ~play;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) timing = 4'($urandom_range(0, 15));
        else timing = 4'($urandom_range(1, 8));
      end
      cyc();
    end
    ld_ins1 = 1'b0; ld_ins2 = 1'b0; ld_ins3 = 1'b0; ld_ins4 = 1'b0; ld_bpm = 1'b0;
    repeat (3) cyc();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
